// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and line levels, used by both the
// transmit and receive paths of the serial link.
package uart_pkg;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/tx_bps_module.sv
// Transmit bit-period counter: counts 0..BPS_DIV-1 while enabled and flags the
// last cycle of each bit period. Same shape as the receive-side baud module.
module tx_bps_module #(
    parameter int BPS_DIV = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = (BPS_DIV > 1) ? $clog2(BPS_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    assign bit_end = enable && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, with internal bit-period timing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Pin_Out,
    output logic       TX_Busy_Sig,
    output logic       TX_Done_Sig
);

    localparam int BPS_DIV = CLK_FREQ / BAUD;

    logic [2:0]           state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx_reg;
    logic                 pin_reg;
    logic                 busy_reg;
    logic                 done_reg;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg;
`endif

    logic accept;
    logic bps_en;
    logic bit_end;

    // A new request is also taken in the DONE cycle so frames can run back to back.
    assign accept = TX_En_Sig && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign bps_en = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

    tx_bps_module #(
        .BPS_DIV (BPS_DIV)
    ) u_bps (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (accept),
        .enable  (bps_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            pin_reg     <= LINE_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    done_reg <= 1'b0;
                    if (accept) begin
                        shift_reg   <= TX_Data;
                        bit_idx_reg <= '0;
                        pin_reg     <= START_LEVEL;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_reg  <= ^TX_Data;
`endif
                    end else begin
                        pin_reg   <= LINE_IDLE;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        pin_reg   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            pin_reg   <= parity_reg;
                            state_reg <= ST_PARITY;
`else
                            pin_reg   <= LINE_IDLE;
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            pin_reg     <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        pin_reg   <= LINE_IDLE;
                        state_reg <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        pin_reg   <= LINE_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    pin_reg   <= LINE_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_Pin_Out  = pin_reg;
    assign TX_Busy_Sig = busy_reg;
    assign TX_Done_Sig = done_reg;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module at BPS_DIV=8; follows UART_TX_PARITY_EN
// for frame length when that macro is defined.
module tb_uart_tx_module;

    localparam int B = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int D    = NBITS * B;
    localparam int CAPN = 2 * D + 40;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       TX_En_Sig = 1'b0;
    logic [7:0] TX_Data = 8'h00;
    logic       TX_Pin_Out;
    logic       TX_Busy_Sig;
    logic       TX_Done_Sig;

    int checks = 0;
    int errors = 0;

    logic cap_line [CAPN];
    logic cap_busy [CAPN];
    logic cap_done [CAPN];

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_byte;
        logic       exp_par;
    } vec_t;
    vec_t vecs [8];

    uart_tx_module #(
        .CLK_FREQ (1_000_000),
        .BAUD     (125_000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .TX_En_Sig   (TX_En_Sig),
        .TX_Data     (TX_Data),
        .TX_Pin_Out  (TX_Pin_Out),
        .TX_Busy_Sig (TX_Busy_Sig),
        .TX_Done_Sig (TX_Done_Sig)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int i);
        cap_line[i] = TX_Pin_Out;
        cap_busy[i] = TX_Busy_Sig;
        cap_done[i] = TX_Done_Sig;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // sel: 0 line, 1 busy, 2 done; actual reported is the first wrong cycle (-1 = none)
    task automatic check_range(input string name, input int sel, input int lo, input int hi, input logic lvl);
        int bad;
        bad = -1;
        for (int i = lo; i <= hi; i++) begin
            logic v;
            v = (sel == 0) ? cap_line[i] : (sel == 1) ? cap_busy[i] : cap_done[i];
            if (v !== lvl && bad < 0) bad = i;
        end
        check(name, bad, -1);
    endtask

    task automatic frame_checks(input string tag, input int base, input logic [7:0] eb, input logic ep);
        logic [7:0] dec;
        for (int b = 0; b < NBITS; b++) begin
            logic lvl;
            if (b == 0)              lvl = 1'b0;
            else if (b <= 8)         lvl = eb[b-1];
            else if (b == NBITS - 1) lvl = 1'b1;
            else                     lvl = ep;
            check_range($sformatf("%s bit%0d", tag, b), 0, base + b*B, base + b*B + B - 1, lvl);
        end
        for (int i = 0; i < 8; i++) dec[i] = cap_line[base + (i+1)*B + B/2];
        check({tag, " decode"}, {24'h0, dec}, {24'h0, eb});
        check_range({tag, " busy"}, 1, base, base + D - 1, 1'b1);
        check_range({tag, " busy@done"}, 1, base + D, base + D, 1'b0);
        check_range({tag, " no early done"}, 2, base, base + D - 1, 1'b0);
        check_range({tag, " done pulse"}, 2, base + D, base + D, 1'b1);
        $display("frame %s expected=%02h decoded=%02h", tag, eb, dec);
    endtask

    task automatic send_single(input string tag, input logic [7:0] data, input logic [7:0] eb, input logic ep);
        TX_Data   = data;
        TX_En_Sig = 1'b1;
        for (int i = 0; i <= D + 3; i++) begin
            tick();
            sample(i);
            if (i == 0) begin
                TX_En_Sig = 1'b0;
                TX_Data   = ~data;
            end
        end
        frame_checks(tag, 0, eb, ep);
        check_range({tag, " idle after"}, 0, D, D + 3, 1'b1);
        check_range({tag, " single done"}, 2, D + 1, D + 3, 1'b0);
        check_range({tag, " not busy after"}, 1, D + 1, D + 3, 1'b0);
    endtask

    initial begin
        vecs[0] = '{data: 8'h55, exp_byte: 8'h55, exp_par: 1'b0};
        vecs[1] = '{data: 8'hA3, exp_byte: 8'hA3, exp_par: 1'b0};
        vecs[2] = '{data: 8'h00, exp_byte: 8'h00, exp_par: 1'b0};
        vecs[3] = '{data: 8'hFF, exp_byte: 8'hFF, exp_par: 1'b0};
        vecs[4] = '{data: 8'h81, exp_byte: 8'h81, exp_par: 1'b0};
        vecs[5] = '{data: 8'h07, exp_byte: 8'h07, exp_par: 1'b1};
        vecs[6] = '{data: 8'h13, exp_byte: 8'h13, exp_par: 1'b1};
        vecs[7] = '{data: 8'h3C, exp_byte: 8'h3C, exp_par: 1'b0};

        // Reset state, then 20 idle cycles
        RST = 1'b1;
        tick();
        check("reset line", {31'h0, TX_Pin_Out}, 1);
        check("reset busy", {31'h0, TX_Busy_Sig}, 0);
        check("reset done", {31'h0, TX_Done_Sig}, 0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample(i);
        end
        check_range("idle line", 0, 0, 19, 1'b1);
        check_range("idle busy", 1, 0, 19, 1'b0);
        check_range("idle done", 2, 0, 19, 1'b0);
        $display("idle 20 cycles observed");

        for (int v = 0; v < 8; v++)
            send_single($sformatf("vec%0d", v), vecs[v].data, vecs[v].exp_byte, vecs[v].exp_par);

        // Request while busy is ignored
        TX_Data   = 8'hA3;
        TX_En_Sig = 1'b1;
        for (int i = 0; i <= D + 20; i++) begin
            tick();
            sample(i);
            if (i == 0)  TX_En_Sig = 1'b0;
            if (i == 29) begin
                TX_En_Sig = 1'b1;
                TX_Data   = 8'hFF;
            end
            if (i == 30) TX_En_Sig = 1'b0;
        end
        frame_checks("busy-ignore", 0, 8'hA3, 1'b0);
        check_range("busy-ignore line after", 0, D, D + 20, 1'b1);
        check_range("busy-ignore done after", 2, D + 1, D + 20, 1'b0);
        check_range("busy-ignore busy after", 1, D + 1, D + 20, 1'b0);

        // Enable held high: back-to-back frames, second accepted in DONE cycle
        TX_Data   = 8'h00;
        TX_En_Sig = 1'b1;
        for (int i = 0; i <= 2*D + 5; i++) begin
            tick();
            sample(i);
            if (i == 0)       TX_Data = 8'h81;
            if (i == 2*D + 1) TX_En_Sig = 1'b0;
        end
        frame_checks("b2b-first", 0, 8'h00, 1'b0);
        frame_checks("b2b-second", D + 1, 8'h81, 1'b0);
        check_range("b2b stop extended", 0, D, D, 1'b1);
        check_range("b2b no third", 2, 2*D + 2, 2*D + 5, 1'b0);
        check_range("b2b idle after", 0, 2*D + 1, 2*D + 5, 1'b1);

        // Reset mid-frame aborts without a done pulse
        TX_Data   = 8'h0F;
        TX_En_Sig = 1'b1;
        for (int i = 0; i <= D + 5; i++) begin
            tick();
            sample(i);
            if (i == 0)  TX_En_Sig = 1'b0;
            if (i == 40) RST = 1'b1;
            if (i == 41) RST = 1'b0;
        end
        check_range("abort pre-reset line", 0, 40, 40, 1'b0);
        check_range("abort pre-reset busy", 1, 0, 40, 1'b1);
        check_range("abort line high", 0, 41, D + 5, 1'b1);
        check_range("abort busy low", 1, 41, D + 5, 1'b0);
        check_range("abort no done", 2, 0, D + 5, 1'b0);
        $display("frame abort data=0f reset at cycle 40");
        send_single("after-abort", 8'h3C, 8'h3C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- 8-bit UART transmitter; serialises one byte per request onto an asynchronous line, LSB first.
- Frame format: 1 start bit, 8 data bits, 1 stop bit (8N1).
- Counterpart of the serial receive path, so both ends of the board's serial link live in the same codebase.
- Contains its own bit-period counter; no external BPS_CLK is needed.
- Fed by a host-side control FSM that presents a byte and waits for the done pulse.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- BPS_DIV (localparam), CLK_FREQ/BAUD (integer division), clock cycles per bit; must be >= 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- TX_En_Sig  input  1  transmit request; sampled only when TX_Busy_Sig=0.
- TX_Data  input  8  byte to send; captured in the cycle TX_En_Sig is accepted.
- TX_Pin_Out  output  1  serial line, registered, idle high.
- TX_Busy_Sig  output  1  high from request acceptance through the end of the stop bit.
- TX_Done_Sig  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (RST=1 at an edge): TX_Pin_Out=1, TX_Busy_Sig=0, TX_Done_Sig=0, shift register=0, bit counter=0, state=IDLE. Reset mid-frame aborts at the next edge; the line returns high immediately and no done pulse is produced.
- FSM states:
  - IDLE: line=1. If TX_En_Sig=1, latch TX_Data, go to START, assert busy, and drive line=0, all at the same edge.
  - START: line=0 for BPS_DIV cycles.
  - DATA: bits D0..D7, each held for BPS_DIV cycles; a 3-bit index counts 0..7.
  - STOP: line=1 for BPS_DIV cycles.
  - DONE: TX_Done_Sig=1, TX_Busy_Sig=0, line=1 for exactly one cycle, then IDLE.
- Timing: take the accepting edge as cycle 0.
  - Start bit occupies cycles 0..BPS_DIV-1.
  - Data bit n occupies cycles (n+1)*BPS_DIV .. (n+2)*BPS_DIV-1.
  - Stop bit occupies 9*BPS_DIV .. 10*BPS_DIV-1.
  - Done pulse is at cycle 10*BPS_DIV.
- Bit-period counter: counts 0..BPS_DIV-1. It is cleared on acceptance and wraps at BPS_DIV-1, where it advances the FSM. Width is $clog2(BPS_DIV).
- TX_En_Sig while busy: ignored, with no queuing. TX_Data changes after acceptance have no effect.
- Back-to-back frames: TX_En_Sig is also accepted in the DONE cycle. The next start bit then begins at the following edge, giving a stop level of BPS_DIV+1 cycles.
- TX_En_Sig held continuously high: frames repeat every 10*BPS_DIV+1 cycles.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of D0..D7) is sent after D7 for BPS_DIV cycles.
  - Stop bit moves to 10*BPS_DIV .. 11*BPS_DIV-1.
  - Done pulse moves to cycle 11*BPS_DIV.
  - A PARITY state is added.
- Undefined: no PARITY state; 8N1 timing as above.

Decomposition:
- Shared package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP, DONE.
  - Constants DATA_BITS=8, LINE_IDLE=1'b1, START_LEVEL=1'b0.
  - Also used by the receive side.
- One sub-module, tx_bps_module:
  - Takes CLK, RST, a clear input and an enable.
  - Produces a one-cycle bit-end tick when the count reaches BPS_DIV-1.
  - Mirrors the receive-side baud module.

Test Plan (CLK_FREQ=1_000_000, BAUD=125_000, so BPS_DIV=8):
- Reset then idle 20 cycles -> TX_Pin_Out=1, TX_Busy_Sig=0, TX_Done_Sig=0 throughout.
- TX_En_Sig pulse with TX_Data=8'h55 -> line in 8-cycle bits reads 0,1,0,1,0,1,0,1,0,1; TX_Done_Sig=1 only at cycle 80; busy high for cycles 0..79.
- TX_Data=8'hA3 accepted, then TX_En_Sig re-pulsed at cycle 30 with TX_Data=8'hFF -> the second request is ignored; serial data decodes 0xA3; only one done pulse.
- TX_En_Sig held high with data 8'h00 then 8'h81 -> second start bit begins at cycle 81; both bytes decode correctly; done pulses at cycles 80 and 161.
- RST asserted at cycle 40 of a 8'h0F frame -> line=1 and busy=0 from cycle 41; no done pulse; a fresh 8'h3C frame afterwards decodes correctly.
- With UART_TX_PARITY_EN defined, TX_Data=8'h07 -> parity bit=1 in cycles 72..79, stop bit in 80..87, done pulse at cycle 88.
